ex_stage: RTL

//  MIPS execute stage plus EX/MEM pipeline register; consumes ID/EX register outputs (WB, M, EX, operands, RegRs/Rt/Rd).

---
 rtl/ex_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with EX/MEM register and iterative signed multiply.
// Define EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  input  logic [3:0]        EX,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  input  logic [DATA_W-1:0] imm_value,
  input  logic [REG_W-1:0]  RegRs,
  input  logic [REG_W-1:0]  RegRt,
  input  logic [REG_W-1:0]  RegRd,
  input  logic              MEMWB_RegWrite,
  input  logic [REG_W-1:0]  MEMWB_RegRd,
  input  logic [DATA_W-1:0] MEMWB_Data,
  output logic              stall,
  output logic [1:0]        WBout,
  output logic [2:0]        Mout,
  output logic [DATA_W-1:0] ALUresult,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_W-1:0]  WriteReg,
  output logic              Zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_W-1:0]     fwd_a, fwd_b, op_b, alu_res;
  logic [DATA_W-1:0]     hi, lo, mplier, mag_a, mag_b;
  logic [2*DATA_W-1:0]   acc, mcand, acc_sum;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            alu_op;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic                  is_mult, start_mult;

`ifdef EX_FWD_EN
  // EX/MEM is checked first so the younger result wins; $0 never forwards.
  always_comb begin
    fwd_a = DataA;
    if (WBout[1] && WriteReg != '0 && WriteReg == RegRs)
      fwd_a = ALUresult;
    else if (MEMWB_RegWrite && MEMWB_RegRd != '0 && MEMWB_RegRd == RegRs)
      fwd_a = MEMWB_Data;
  end

  always_comb begin
    fwd_b = DataB;
    if (WBout[1] && WriteReg != '0 && WriteReg == RegRt)
      fwd_b = ALUresult;
    else if (MEMWB_RegWrite && MEMWB_RegRd != '0 && MEMWB_RegRd == RegRt)
      fwd_b = MEMWB_Data;
  end
`else
  logic unused_memwb;
  assign unused_memwb = ^{MEMWB_RegWrite, MEMWB_RegRd, MEMWB_Data};
  assign fwd_a = DataA;
  assign fwd_b = DataB;
`endif

  assign alu_op     = EX[2:1];
  assign funct      = imm_value[5:0];
  assign shamt      = imm_value[10:6];
  assign op_b       = EX[0] ? imm_value : fwd_b;
  assign is_mult    = (alu_op == 2'b10) && (funct == 6'h18);
  assign start_mult = (state == IDLE) && is_mult && !flush;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      2'b11: alu_res = fwd_a | op_b;
      default: begin
        case (funct)
          6'h20: alu_res = fwd_a + op_b;
          6'h22: alu_res = fwd_a - op_b;
          6'h24: alu_res = fwd_a & op_b;
          6'h25: alu_res = fwd_a | op_b;
          6'h2A: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
          6'h00: alu_res = fwd_b << shamt;
          6'h10: alu_res = hi;
          6'h12: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_mult && !flush) state_next = MUL;
      MUL: begin
        if (flush)                          state_next = IDLE;
        else if (cnt == CNT_W'(DATA_W - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = is_mult && !flush;
      MUL:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall && reset_n;
  end

  // Shift-add on magnitudes; the sign is reapplied when the product is committed.
  assign mag_a   = fwd_a[DATA_W-1] ? -fwd_a : fwd_a;
  assign mag_b   = fwd_b[DATA_W-1] ? -fwd_b : fwd_b;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (start_mult) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= fwd_a[DATA_W-1] ^ fwd_b[DATA_W-1];
      cnt    <= '0;
    end else if (state == MUL && !flush) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(DATA_W - 1))
        {hi, lo} <= neg ? -acc_sum : acc_sum;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      WBout     <= '0;
      Mout      <= '0;
      ALUresult <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
      Zero      <= 1'b0;
    end else begin
      if (stall || flush) begin
        WBout <= '0;
        Mout  <= '0;
      end else begin
        WBout <= WB;
        Mout  <= M;
      end
      ALUresult <= alu_res;
      WriteData <= fwd_b;
      WriteReg  <= EX[3] ? RegRd : RegRt;
      Zero      <= (alu_res == '0);
    end
  end

endmodule
